// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I load/store writeback stage.
package riscv_pkg;

  localparam int XLEN = 32;

  // Writeback source select coming from decode.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size as decoded from funct3[1:0].
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } lsu_state_e;

  // Byte/half/word from funct3; every encoding other than 00/01 in the low
  // bits (including the unused 011/110/111) behaves as a full word.
  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_size = SZ_BYTE;
      2'b01:   access_size = SZ_HALF;
      default: access_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the LSU: store byte-enables and data
// replication, load lane select with sign/zero extension, misalign detect.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      mask,
  output logic [XLEN-1:0] store_wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misalign
);

  logic [1:0] size;
  logic       is_byte;
  logic       is_half;

  assign size    = access_size(funct3);
  assign is_byte = (size == SZ_BYTE);
  assign is_half = (size == SZ_HALF);

  // Halves must be 2-byte aligned, words 4-byte aligned; bytes never fault.
  assign misalign = is_half ? addr_lo[0] : (!is_byte && (addr_lo != 2'b00));

  // Per byte lane: enable and replicated store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign mask[gi] = is_byte ? (addr_lo == LANE)
                      : is_half ? (addr_lo[1] == LANE[1])
                      : 1'b1;
      assign store_wdata[8*gi +: 8] = is_byte ? store_data[7:0]
                                    : is_half ? store_data[8*(gi%2) +: 8]
                                    : store_data[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_wb_stage.sv
// Memory/writeback stage of the 3-stage RV32I pipeline. Holds one
// instruction, runs its data access over a req/rsp handshake with a timeout,
// and drives the register-file write port.
module lsu_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [4:0]      ex_rd,
  input  logic            ex_rf_en,
  input  logic [1:0]      ex_wb_sel,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic [2:0]      ex_funct3,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_mask,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wdata,
  output logic            exc_misalign,
  output logic            exc_bus_err
);

  localparam int            CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  // Stage register.
  logic            s_valid_reg;
  logic [XLEN-1:0] s_alu_reg;
  logic [XLEN-1:0] s_rs2_reg;
  logic [XLEN-1:0] s_pc_reg;
  logic [4:0]      s_rd_reg;
  logic            s_rf_en_reg;
  logic [1:0]      s_wb_sel_reg;
  logic            s_mem_rd_reg;
  logic            s_mem_wr_reg;
  logic [2:0]      s_funct3_reg;

  lsu_state_e      state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic [3:0]      al_mask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load;
  logic            al_misalign;
  logic            is_mem;
  logic            write_ok;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3      (s_funct3_reg),
    .addr_lo     (s_alu_reg[1:0]),
    .store_data  (s_rs2_reg),
    .rdata       (dmem_rdata),
    .mask        (al_mask),
    .store_wdata (al_wdata),
    .load_data   (al_load),
    .misalign    (al_misalign)
  );

  assign is_mem = s_valid_reg && (s_mem_rd_reg || s_mem_wr_reg);

  // Handshake control: outputs are decoded from the registered state so an
  // instruction can retire in the same cycle it sits in the stage.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    stall        = 1'b0;
    dmem_req     = 1'b0;
    write_ok     = 1'b0;
    exc_misalign = 1'b0;
    exc_bus_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (is_mem && !al_misalign) begin
          dmem_req   = 1'b1;
          stall      = 1'b1;
          state_next = WAIT_RSP;
        end else if (is_mem) begin
          exc_misalign = 1'b1;
        end else begin
          write_ok = s_valid_reg && s_rf_en_reg;
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          write_ok   = s_mem_rd_reg && s_rf_en_reg;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          exc_bus_err = 1'b1;
          state_next  = IDLE;
          cnt_next    = '0;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign rf_en      = write_ok && (s_rd_reg != 5'd0);
  assign rd         = s_rd_reg;
  assign dmem_we    = dmem_req && s_mem_wr_reg;
  assign dmem_addr  = dmem_req ? {s_alu_reg[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata = (dmem_req && s_mem_wr_reg) ? al_wdata : '0;
  assign dmem_mask  = dmem_req ? al_mask : 4'd0;

  // Writeback source mux.
  always_comb begin
    case (s_wb_sel_reg)
      WB_ALU:  wdata = s_alu_reg;
      WB_LOAD: wdata = al_load;
      WB_PC4:  wdata = s_pc_reg + XLEN'(4);
      default: wdata = '0;
    endcase
  end

  // FSM, wait counter and stage register; the stage only loads when not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      s_valid_reg  <= 1'b0;
      s_alu_reg    <= '0;
      s_rs2_reg    <= '0;
      s_pc_reg     <= '0;
      s_rd_reg     <= '0;
      s_rf_en_reg  <= 1'b0;
      s_wb_sel_reg <= 2'b00;
      s_mem_rd_reg <= 1'b0;
      s_mem_wr_reg <= 1'b0;
      s_funct3_reg <= 3'b000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!stall) begin
        s_valid_reg  <= ex_valid;
        s_alu_reg    <= ex_alu_result;
        s_rs2_reg    <= ex_rs2_data;
        s_pc_reg     <= ex_pc;
        s_rd_reg     <= ex_rd;
        s_rf_en_reg  <= ex_rf_en;
        s_wb_sel_reg <= ex_wb_sel;
        s_mem_rd_reg <= ex_mem_rd;
        s_mem_wr_reg <= ex_mem_wr;
        s_funct3_reg <= ex_funct3;
      end
    end
  end

endmodule
